// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem fetch, IF/ID register.
// Define IF_STATIC_BP_EN for static prediction of jal and backward branches.
module if_stage #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [31:0]     imem_resp_data_i,
  output logic            if_id_valid_o,
  output logic [31:0]     if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic            if_id_pred_taken_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            pred;
  } slot_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  slot_t           hold_q, hold_d;
  slot_t           ifid_q, ifid_d;
  logic            ifid_vld_q, ifid_vld_d;

  logic            req_fire;
  logic            resp_take;
  logic            ifid_free;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] redir_tgt;
  logic            pred_taken;
  logic [XLEN-1:0] pred_tgt;
  slot_t           fetched;

  assign pc_seq    = pc_q + XLEN'(4);
  assign redir_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};

`ifdef IF_STATIC_BP_EN
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] raw_tgt;
  logic            is_jal;
  logic            is_bwd;

  assign j_imm = {{(XLEN-20){imem_resp_data_i[31]}},
                  imem_resp_data_i[19:12],
                  imem_resp_data_i[20],
                  imem_resp_data_i[30:21], 1'b0};
  assign b_imm = {{(XLEN-12){imem_resp_data_i[31]}},
                  imem_resp_data_i[7],
                  imem_resp_data_i[30:25],
                  imem_resp_data_i[11:8], 1'b0};
  assign is_jal = imem_resp_data_i[6:0] == 7'b1101111;
  assign is_bwd = (imem_resp_data_i[6:0] == 7'b1100011)
                  && imem_resp_data_i[31];
  assign raw_tgt = pc_q + (is_jal ? j_imm : b_imm);
  assign pred_taken = is_jal | is_bwd;
  assign pred_tgt = {raw_tgt[XLEN-1:2], 2'b00};
`else
  assign pred_taken = 1'b0;
  assign pred_tgt   = pc_seq;
`endif

  assign pc_next = pred_taken ? pred_tgt : pc_seq;

  assign imem_req_valid_o = (state_q == S_REQ) && !rst;
  assign imem_req_addr_o  = pc_q;
  assign req_fire  = imem_req_valid_o && imem_req_ready_i;
  assign resp_take = (state_q == S_WAIT) && imem_resp_valid_i;
  assign ifid_free = !id_stall_i || !ifid_vld_q;

  assign fetched.pc    = pc_q;
  assign fetched.instr = imem_resp_data_i;
  assign fetched.pred  = pred_taken;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    hold_d     = hold_q;
    ifid_d     = ifid_q;
    ifid_vld_d = ifid_vld_q;

    if (!(id_stall_i && ifid_vld_q)) begin
      ifid_vld_d   = 1'b0;
      ifid_d.instr = NOP_INSTR;
      ifid_d.pred  = 1'b0;
    end

    unique case (state_q)
      S_REQ: begin
        if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_take) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (ifid_free) begin
            ifid_d     = fetched;
            ifid_vld_d = 1'b1;
            pc_d       = pc_next;
            state_d    = S_REQ;
          end else begin
            hold_d  = fetched;
            pc_d    = pc_next;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!id_stall_i) begin
          ifid_d     = hold_q;
          ifid_vld_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect beats stall and any response in flight.
    if (redirect_valid_i) begin
      pc_d         = redir_tgt;
      ifid_vld_d   = 1'b0;
      ifid_d.instr = NOP_INSTR;
      ifid_d.pred  = 1'b0;
      hold_d       = '0;
      unique case (state_q)
        S_REQ: begin
          state_d   = req_fire ? S_WAIT : S_REQ;
          discard_d = req_fire;
        end
        S_WAIT: begin
          state_d   = resp_take ? S_REQ : S_WAIT;
          discard_d = !resp_take;
        end
        default: begin
          state_d   = S_REQ;
          discard_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      hold_q       <= '0;
      ifid_q.pc    <= '0;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pred  <= 1'b0;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
      ifid_q     <= ifid_d;
      ifid_vld_q <= ifid_vld_d;
    end
  end

  assign if_id_valid_o      = ifid_vld_q;
  assign if_id_instr_o      = ifid_q.instr;
  assign if_id_pc_o         = ifid_q.pc;
  assign if_id_pred_taken_o = ifid_q.pred;

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage: fetch, stall/hold, redirects, reset,
// PC wrap and (with IF_STATIC_BP_EN) static branch prediction.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [63:0] if_id_pc_o;
  logic        if_id_pred_taken_o;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IF_STATIC_BP_EN
  localparam logic        BWD_PRED = 1'b1;
  localparam logic [63:0] BWD_NEXT = 64'h8000_0008;
`else
  localparam logic        BWD_PRED = 1'b0;
  localparam logic [63:0] BWD_NEXT = 64'h8000_0014;
`endif

  if_stage dut (
    .clk                (clk),
    .rst                (rst),
    .id_stall_i         (id_stall_i),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_pc_i      (redirect_pc_i),
    .imem_req_valid_o   (imem_req_valid_o),
    .imem_req_ready_i   (imem_req_ready_i),
    .imem_req_addr_o    (imem_req_addr_o),
    .imem_resp_valid_i  (imem_resp_valid_i),
    .imem_resp_data_i   (imem_resp_data_i),
    .if_id_valid_o      (if_id_valid_o),
    .if_id_instr_o      (if_id_instr_o),
    .if_id_pc_o         (if_id_pc_o),
    .if_id_pred_taken_o (if_id_pred_taken_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic vld,
                          input logic [31:0] ins, input logic [63:0] pc);
    chk({tag, ".valid"}, 64'(if_id_valid_o), 64'(vld));
    chk({tag, ".instr"}, 64'(if_id_instr_o), 64'(ins));
    chk({tag, ".pc"}, if_id_pc_o, pc);
  endtask

  initial begin
    rst = 1'b1;
    id_stall_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i = '0;

    // reset state
    step();
    chk("rst.req_valid", 64'(imem_req_valid_o), 0);
    chk_ifid("rst", 1'b0, NOP, 64'h0);
    chk("rst.pred", 64'(if_id_pred_taken_o), 0);
    rst = 1'b0;
    #1;
    chk("first.req_valid", 64'(imem_req_valid_o), 1);
    chk("first.addr", imem_req_addr_o, 64'h8000_0000);

    // basic fetch stream
    imem_req_ready_i = 1'b1;
    step();
    chk("wait.req_valid", 64'(imem_req_valid_o), 0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0010_0093;
    step();
    imem_resp_valid_i = 1'b0;
    chk_ifid("i0", 1'b1, 32'h0010_0093, 64'h8000_0000);
    chk("i0.addr", imem_req_addr_o, 64'h8000_0004);
    chk("i0.req_valid", 64'(imem_req_valid_o), 1);
    step();
    chk("gap.valid", 64'(if_id_valid_o), 0);
    chk("gap.instr", 64'(if_id_instr_o), 64'(NOP));
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0020_0113;
    step();
    imem_resp_valid_i = 1'b0;
    chk_ifid("i1", 1'b1, 32'h0020_0113, 64'h8000_0004);
    chk("i1.addr", imem_req_addr_o, 64'h8000_0008);

    // stall for 3 cycles, response lands in hold buffer
    id_stall_i = 1'b1;
    step();
    chk_ifid("stall1", 1'b1, 32'h0020_0113, 64'h8000_0004);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0030_0193;
    step();
    imem_resp_valid_i = 1'b0;
    chk_ifid("stall2", 1'b1, 32'h0020_0113, 64'h8000_0004);
    chk("hold.req_valid", 64'(imem_req_valid_o), 0);
    step();
    chk_ifid("stall3", 1'b1, 32'h0020_0113, 64'h8000_0004);
    chk("hold2.req_valid", 64'(imem_req_valid_o), 0);
    id_stall_i = 1'b0;
    step();
    chk_ifid("unhold", 1'b1, 32'h0030_0193, 64'h8000_0008);
    chk("unhold.addr", imem_req_addr_o, 64'h8000_000C);
    chk("unhold.req_valid", 64'(imem_req_valid_o), 1);

    // redirect while waiting; stale response dropped
    step();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h8000_0101;
    step();
    redirect_valid_i = 1'b0;
    chk_ifid("rdw", 1'b0, NOP, 64'h8000_0008);
    chk("rdw.req_valid", 64'(imem_req_valid_o), 0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0000_0000;
    step();
    imem_resp_valid_i = 1'b0;
    chk("stale.valid", 64'(if_id_valid_o), 0);
    chk("stale.instr", 64'(if_id_instr_o), 64'(NOP));
    chk("stale.req_valid", 64'(imem_req_valid_o), 1);
    chk("stale.addr", imem_req_addr_o, 64'h8000_0100);

    // redirect coinciding with handshake
    imem_req_ready_i = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h8000_0200;
    step();
    redirect_valid_i = 1'b0;
    chk("rdh.req_valid", 64'(imem_req_valid_o), 0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0050_0293;
    step();
    imem_resp_valid_i = 1'b0;
    chk("rdh.valid", 64'(if_id_valid_o), 0);
    chk("rdh.addr", imem_req_addr_o, 64'h8000_0200);
    chk("rdh.req_valid", 64'(imem_req_valid_o), 1);

    // redirect together with stall
    step();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0060_0313;
    step();
    imem_resp_valid_i = 1'b0;
    chk_ifid("pre_rs", 1'b1, 32'h0060_0313, 64'h8000_0200);
    imem_req_ready_i = 1'b0;
    id_stall_i = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h8000_0300;
    step();
    id_stall_i = 1'b0;
    redirect_valid_i = 1'b0;
    chk("rs.valid", 64'(if_id_valid_o), 0);
    chk("rs.instr", 64'(if_id_instr_o), 64'(NOP));
    chk("rs.addr", imem_req_addr_o, 64'h8000_0300);

    // reset while waiting, late response ignored
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    rst = 1'b1;
    step();
    chk("rst2.req_valid", 64'(imem_req_valid_o), 0);
    rst = 1'b0;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'hDEAD_BEEF;
    step();
    imem_resp_valid_i = 1'b0;
    chk("rst2.valid", 64'(if_id_valid_o), 0);
    chk("rst2.addr", imem_req_addr_o, 64'h8000_0000);
    imem_req_ready_i = 1'b1;
    step();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0070_0393;
    step();
    imem_resp_valid_i = 1'b0;
    chk_ifid("rst2.i", 1'b1, 32'h0070_0393, 64'h8000_0000);

    // PC wrap at top of address space
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid_i = 1'b0;
    chk("wrap.addr0", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready_i = 1'b1;
    step();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0080_0413;
    step();
    imem_resp_valid_i = 1'b0;
    chk_ifid("wrap", 1'b1, 32'h0080_0413, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.addr1", imem_req_addr_o, 64'h0);

    // backward beq -8 at 0x80000010
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h8000_0010;
    step();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    step();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'hFE00_0CE3;
    step();
    imem_resp_valid_i = 1'b0;
    chk_ifid("bwd", 1'b1, 32'hFE00_0CE3, 64'h8000_0010);
    chk("bwd.pred", 64'(if_id_pred_taken_o), 64'(BWD_PRED));
    chk("bwd.addr", imem_req_addr_o, BWD_NEXT);

    // forward beq +8 at 0x80000010
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h8000_0010;
    step();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    step();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0000_0463;
    step();
    imem_resp_valid_i = 1'b0;
    chk_ifid("fwd", 1'b1, 32'h0000_0463, 64'h8000_0010);
    chk("fwd.pred", 64'(if_id_pred_taken_o), 0);
    chk("fwd.addr", imem_req_addr_o, 64'h8000_0014);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
